// File: rtl/seq_signed_divider_if.sv
// Handshake and data bundle for the sequential signed divider.
// The requester drives start and operands; the divider returns status and results.
interface seq_signed_divider_if #(
  parameter int unsigned DW = 9,
  parameter int unsigned VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Sequential two's-complement divider: restoring division on magnitudes, one
// quotient bit per clock, then sign correction. Truncating semantics, so the
// remainder takes the sign of the dividend.
module seq_signed_divider #(
  parameter int unsigned DW = 9,
  parameter int unsigned VW = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_signed_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] rem_q;      // partial remainder, always < divisor magnitude
  logic [DW-1:0] quo_q;      // dividend magnitude shifts out at MSB, quotient bits enter at LSB
  logic [VW-1:0] dvs_mag_q;
  logic          dvd_neg_q;
  logic          dvs_neg_q;

  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   rem_shift;
  logic [VW-1:0] rem_diff;
  logic          sub_ok;
  logic          zero_div;
  logic          ovf_det;

  // Operand magnitudes, one restoring step, and result classification.
  always_comb begin
    dvd_mag   = bus.dividend[DW-1] ? (~bus.dividend + DW'(1)) : bus.dividend;
    dvs_mag   = bus.divisor[VW-1] ? (~bus.divisor + VW'(1)) : bus.divisor;
    rem_shift = {rem_q, quo_q[DW-1]};
    sub_ok    = rem_shift >= {1'b0, dvs_mag_q};
    // Only used when the true difference is non-negative and < divisor, so VW bits suffice.
    rem_diff  = rem_shift[VW-1:0] - dvs_mag_q;
    zero_div  = (dvs_mag_q == '0);
    // With |divisor|==1 the quotient magnitude equals |dividend|, so 2^(DW-1) means -2^(DW-1).
    ovf_det   = dvd_neg_q && dvs_neg_q && (dvs_mag_q == VW'(1)) &&
                (quo_q == {1'b1, {(DW-1){1'b0}}});
  end

  // Control FSM with registered outputs: IDLE -> CALC (DW steps) -> SIGN -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_mag_q     <= '0;
      dvd_neg_q     <= 1'b0;
      dvs_neg_q     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            quo_q     <= dvd_mag;
            dvs_mag_q <= dvs_mag;
            dvd_neg_q <= bus.dividend[DW-1];
            dvs_neg_q <= bus.divisor[VW-1];
            rem_q     <= '0;
            cnt_q     <= CW'(DW - 1);
            bus.busy  <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          rem_q <= sub_ok ? rem_diff : rem_shift[VW-1:0];
          quo_q <= {quo_q[DW-2:0], sub_ok};
          if (cnt_q == '0) begin
            state_q <= StSign;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StSign: begin
          if (zero_div) begin
            bus.quotient  <= '1;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b1;
            bus.ovf       <= 1'b0;
          end else begin
            bus.quotient  <= (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + DW'(1)) : quo_q;
            bus.remainder <= dvd_neg_q ? (~rem_q + VW'(1)) : rem_q;
            bus.div_zero  <= 1'b0;
            bus.ovf       <= ovf_det;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases plus a
// randomized sweep against an integer-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int unsigned DW = 9;
  localparam int unsigned VW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  seq_signed_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division (truncating) plus the two special cases.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] eq, output logic [VW-1:0] er,
                       output logic edz, output logic eovf);
    int sa;
    int sb;
    int q;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    edz  = 1'b0;
    eovf = 1'b0;
    if (sb == 0) begin
      edz = 1'b1;
      q   = -1;
      r   = 0;
    end else if (sa == -(1 << (DW - 1)) && sb == -1) begin
      eovf = 1'b1;
      q    = -(1 << (DW - 1));
      r    = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    eq = DW'(q);
    er = VW'(r);
  endtask

  // Runs one operation starting at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit poke);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    logic          eovf;
    int            cyc;
    bit            seen;
    bit            busy_ok;
    int            lhs;
    model(a, b, eq, er, edz, eovf);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    cyc     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (poke && cyc == 3) bus.start = 1'b1;
      if (poke && cyc == 5) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(seen ? cyc : 0), 32'(DW + 1));
    if (seen) begin
      check("busy_during_op", 32'(busy_ok), 32'd1);
      check("busy_at_done", 32'(bus.busy), 32'd0);
      check("quotient", 32'(bus.quotient), 32'(eq));
      check("remainder", 32'(bus.remainder), 32'(er));
      check("div_zero", 32'(bus.div_zero), 32'(edz));
      check("ovf", 32'(bus.ovf), 32'(eovf));
      if (!edz && !eovf) begin
        lhs = int'($signed(bus.quotient)) * int'($signed(b)) + int'($signed(bus.remainder));
        check("invariant", 32'(lhs), 32'(int'($signed(a))));
      end
    end
  endtask

  initial begin
    int done_cnt;
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_flags", 32'({bus.div_zero, bus.ovf}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, back to back.
    run_op(DW'(100), VW'(7), 1'b0);
    run_op(DW'(-100), VW'(7), 1'b0);
    run_op(DW'(100), VW'(-7), 1'b0);
    run_op(DW'(-100), VW'(-7), 1'b0);
    run_op(DW'(120), VW'(-8), 1'b0);
    run_op(DW'(-256), VW'(-1), 1'b0);
    run_op(DW'(37), VW'(0), 1'b0);
    @(negedge clk);
    check("held_quotient", 32'(bus.quotient), 32'h1ff);
    check("held_div_zero", 32'(bus.div_zero), 32'd1);
    check("done_pulse_low", 32'(bus.done), 32'd0);
    run_op(DW'(9), VW'(3), 1'b0);

    // Start pulsed mid-calculation with fresh operands must be ignored.
    run_op(DW'(100), VW'(7), 1'b1);

    // Reset mid-calculation aborts the operation.
    bus.start    = 1'b1;
    bus.dividend = DW'(-77);
    bus.divisor  = VW'(5);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_op(DW'(9), VW'(3), 1'b0);

    // Extreme dividends against every divisor.
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] a;
      case (i)
        0:       a = DW'(-256);
        1:       a = DW'(255);
        2:       a = DW'(0);
        default: a = DW'(-1);
      endcase
      for (int j = 0; j < 16; j++) run_op(a, VW'(j), 1'b0);
    end

    // Randomized sweep.
    for (int k = 0; k < 1500; k++) run_op(DW'($urandom), VW'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
